// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core pipeline control.
//   ST_*       : pipeline_ctrl state encoding
//   REG_ZERO   : architectural x0 register index
//   NOP_INSTR  : encoding the stage registers load when flushed or bubbled
package core_pkg;

    localparam int unsigned STATE_W    = 2;
    localparam int unsigned REG_IDX_W  = 5;
    localparam int unsigned WAIT_CNT_W = 16;
    localparam int unsigned INSTR_W    = 32;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_RUN      = 2'd0;
    localparam state_t ST_MEM_WAIT = 2'd1;
    localparam state_t ST_FAULT    = 2'd2;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    // addi x0, x0, 0
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and holds at all-ones.
//   clk, rst : clock and synchronous active-high reset
//   inc      : count this cycle
//   q        : current count
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (inc && (q_q != '1)) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencer for the 5-stage RV32I core.
// Combines the ID load-use check, the EX branch redirect and the MEM data
// memory handshake into per-stage enable/flush/bubble controls, with a
// timeout-to-fault wait FSM and saturating stall/flush counters.
//   Inputs : id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken,
//            mem_req, dmem_ready
//   Outputs: dmem_valid, stage enables, if_id_flush, id_ex_flush,
//            mem_wb_bubble (all combinational), mem_fault, stall_cnt,
//            flush_cnt (registered)
module pipeline_ctrl
    import core_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic [4:0]           ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_branch_taken,
    input  logic                 mem_req,
    input  logic                 dmem_ready,
    output logic                 dmem_valid,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 id_ex_en,
    output logic                 ex_mem_en,
    output logic                 mem_wb_en,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 mem_wb_bubble,
    output logic                 mem_fault,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = 16'(WAIT_LIMIT - 1);

    state_t                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    mem_fault_q, mem_fault_d;

    logic active;
    logic load_use;
    logic mem_hold;
    logic stall_inc;
    logic flush_inc;

    assign active   = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);
    assign load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign mem_hold = active && mem_req && !dmem_ready;

    // State, wait counter and sticky fault registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mem_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_fault_q <= mem_fault_d;
        end
    end

    // Next-state and wait counter
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_fault_d = mem_fault_q;
        case (state_q)
            ST_RUN: begin
                wait_cnt_d = '0;
                if (mem_hold) begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                // mem_req dropping mid-wait is a protocol error: resume, no fault
                if (!mem_req || dmem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = ST_FAULT;
                    wait_cnt_d  = '0;
                    mem_fault_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'(1);
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Stage controls; memory hold outranks branch, branch outranks load-use
    always_comb begin
        dmem_valid    = 1'b0;
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_en     = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        if (rst) begin
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (active) begin
            dmem_valid = mem_req;
            if (mem_hold) begin
                mem_wb_bubble = 1'b1;
            end else if (ex_branch_taken) begin
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
                id_ex_flush = 1'b1;
            end else begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
            end
        end
    end

    assign stall_inc = active && !pc_en;
    assign flush_inc = if_id_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .q   (flush_cnt)
    );

    assign mem_fault = mem_fault_q;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline sequencer for the 5-stage RV32I core. It combines three inputs each cycle: the load-use check on ID operands, the branch-taken redirect from EX and the data-memory valid/ready handshake from MEM. From these it drives per-stage enable, flush and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It owns a small FSM for multi-cycle data-memory waits with a timeout-to-fault path, plus saturating stall and flush performance counters.

## Interface
- WAIT_LIMIT, 255: maximum consecutive MEM_WAIT cycles before fault; legal range 1..65535.
- CNT_W, 32: width of performance counters.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1  in  5  rs1 of instruction in ID.
- id_rs2  in  5  rs2 of instruction in ID.
- ex_rd  in  5  destination of instruction in EX.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- mem_req  in  1  instruction in MEM needs data memory (load or store).
- dmem_ready  in  1  data memory completes the access this cycle.
- dmem_valid  out  1  request valid to data memory.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register update enables.
- if_id_flush, id_ex_flush  out  1 each  load a NOP into that register.
- mem_wb_bubble  out  1  load a NOP into MEM/WB.
- mem_fault  out  1  sticky timeout indication.
- stall_cnt  out  CNT_W  cycles in which the PC was held, excluding FAULT.
- flush_cnt  out  CNT_W  cycles in which a branch flush was applied.

## Operation
- States: RUN, MEM_WAIT, FAULT. Reset state is RUN.
- load_use = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
- mem_hold = mem_req & ~dmem_ready, evaluated in RUN or MEM_WAIT.
- Priority, evaluated per cycle:
  - FAULT: all enables 0, all flushes/bubble 0, dmem_valid 0. Leaves only on rst.
  - mem_hold: all five enables 0 and mem_wb_bubble 1. The branch and load-use conditions are held and re-evaluated when the hold ends, because the EX and ID contents stay frozen.
  - ex_branch_taken: all enables 1, if_id_flush 1, id_ex_flush 1. Branch wins over load_use, since the ID instruction is squashed.
  - load_use: pc_en 0, if_id_en 0, id_ex_en 1 with id_ex_flush 1, ex_mem_en 1, mem_wb_en 1.
  - Otherwise: all enables 1, no flushes.
- dmem_valid = mem_req in RUN and MEM_WAIT.
- Transitions:
  - RUN to MEM_WAIT on mem_hold.
  - MEM_WAIT to RUN on dmem_ready; the pipeline advances in that same cycle.
  - MEM_WAIT to FAULT when wait_cnt == WAIT_LIMIT-1 and dmem_ready is 0.
  - MEM_WAIT to RUN if mem_req drops. This is a protocol error and is not counted as a fault.
- wait_cnt (16 bits):
  - Cleared in RUN.
  - Increments each MEM_WAIT cycle without dmem_ready.
  - Cleared on exit from MEM_WAIT.
- mem_fault: set on entry to FAULT, cleared only by rst.
- Counters:
  - stall_cnt increments when pc_en == 0 in RUN or MEM_WAIT.
  - flush_cnt increments when if_id_flush == 1.
  - Both saturate at all-ones and never wrap.

## Timing
- All control outputs are combinational from current state and inputs, so they act in the same cycle.
- State, wait_cnt, mem_fault and the counters are registered.
- While rst == 1: all enables 0, if_id_flush 1, id_ex_flush 1, mem_wb_bubble 1, dmem_valid 0. On the following edge: state RUN, wait_cnt 0, mem_fault 0, both counters 0.
- rst asserted mid-MEM_WAIT or in FAULT: the state is RUN one cycle after rst deasserts; an in-flight memory access is abandoned.
- Zero-wait access (mem_req and dmem_ready in the same RUN cycle): no stall, stays in RUN.
- An N-cycle memory wait stalls the PC for exactly N cycles and adds N to stall_cnt.
- A load-use stall lasts exactly 1 cycle; the next cycle sees ex_mem_read == 0 (bubble) and proceeds.

## Structure
- Shared package core_pkg holds:
  - state encoding constants ST_RUN = 2'd0, ST_MEM_WAIT = 2'd1, ST_FAULT = 2'd2;
  - REG_ZERO = 5'd0;
  - a NOP encoding constant used by the stage registers.
- One natural sub-module: sat_counter (parameter W, inputs clk, rst, inc; output q, saturating), instantiated twice.
- load_use is computed locally. It must not instantiate hazard_unit, because the stall policy is owned here.

## Test plan
- id_rs1=5, id_rs2=2, ex_rd=5, ex_mem_read=1, mem_req=0 -> pc_en=0, if_id_en=0, id_ex_flush=1 for one cycle, stall_cnt=1.
- ex_rd=0, id_rs1=0, ex_mem_read=1 -> no stall, all enables 1.
- Load-use condition together with ex_branch_taken=1 -> pc_en=1, if_id_flush=1, id_ex_flush=1, flush_cnt +1, stall_cnt unchanged.
- mem_req=1 with dmem_ready low for 3 cycles, then high -> all enables 0 and mem_wb_bubble=1 for 3 cycles, advance on the 4th, stall_cnt=3, state back to RUN.
- WAIT_LIMIT=4, mem_req=1 with dmem_ready held 0 -> FAULT after 4 wait cycles, mem_fault=1, dmem_valid=0; then rst -> RUN, mem_fault=0.
- Branch taken during a 2-cycle memory wait -> no flush while waiting; flush asserted in the dmem_ready cycle, flush_cnt +1.
